io_ctrl_unit: RTL and testbench
===============================

Name: io_ctrl_unit

Overview:
Responder for the IO control signals produced by instruction decode (IO_Enable, IO_Selection, Draw_Select). It executes OUT, IN, GETC, DWPX and DWCH.
- Latches output values.
- Waits for the user Enter press on IN.
- Buffers keyboard codes for GETC.
- Runs a req/ack handshake with the video drawer.
- Drives IO_Stall to freeze the PC while an operation is pending.
It sits between the datapath/register file and board peripherals.

Parameters:
DATA_W, 32, datapath word width
SW_W, 16, switch bank width (zero-extended to DATA_W)
KEY_DEPTH, 4, keyboard FIFO entries (power of 2, >=2)

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  synchronous, active-low reset
IO_Enable  in  1  IO instruction present (decode)
IO_Selection  in  2  0=OUT, 1=IN, 2=GETC, 3=DRAW
Draw_Select  in  2  draw mode (0=pixel, 1=char), used when IO_Selection=3
Op_A  in  DATA_W  rs value (OUT data / draw position)
Op_B  in  DATA_W  rt value (draw colour/char)
Switches  in  SW_W  board switches, already synchronous
Enter_Btn  in  1  raw Enter button, active-high, asynchronous
Key_Valid  in  1  one-cycle strobe, new key code
Key_Code  in  8  keyboard code
Draw_Ack  in  1  drawer done, level or pulse
IO_Read_Data  out  DATA_W  value for register write-back (IN/GETC)
IO_Stall  out  1  hold PC/pipeline
Out_Display  out  DATA_W  last OUT value
Draw_Req  out  1  draw request
Draw_Mode  out  2  latched Draw_Select
Draw_Pos  out  DATA_W  latched Op_A
Draw_Data  out  DATA_W  latched Op_B
Key_Overflow  out  1  sticky: key dropped while FIFO full

Behaviour:
- Reset (Reset_n=0 at a clock edge): state IDLE; all outputs 0; FIFO empty; synchroniser and edge-detect regs cleared. Reset mid-operation aborts it and drops Draw_Req the next edge.
- Enter_Btn passes a 2-FF synchroniser plus a rising-edge detect; Enter_Rise is a 1-cycle pulse, 3 cycles after the raw edge.
- FSM states: IDLE, WAIT_IN, WAIT_KEY, DRAW, DONE.
- IO_Stall = (IDLE & IO_Enable & IO_Selection!=0) | state in {WAIT_IN, WAIT_KEY, DRAW}. This is combinational and is 0 in DONE.
- IDLE, OUT: Out_Display <= Op_A at the edge. No stall. Stay IDLE.
- IDLE, IN: go to WAIT_IN.
  - WAIT_IN on Enter_Rise: IO_Read_Data <= zero-extended Switches, go to DONE.
  - An Enter_Rise seen while IDLE is discarded.
- IDLE, GETC: go to WAIT_KEY.
  - WAIT_KEY with FIFO non-empty: pop; IO_Read_Data <= {zeros, head}; go to DONE.
  - Minimum GETC latency is 1 stall cycle.
- IDLE, DRAW: latch Draw_Mode, Draw_Pos, Draw_Data; Draw_Req <= 1; go to DRAW.
  - DRAW on Draw_Ack=1: Draw_Req <= 0; go to DONE.
  - Draw_Req stays high and the latched fields stay stable until Ack.
- DONE: lasts one cycle. The instruction retires at this edge and the RF captures IO_Read_Data. IO_Enable is ignored in DONE so the same instruction does not retrigger. Next state IDLE.
- IO_Read_Data holds its value until the next capture.
- Key FIFO:
  - Push on Key_Valid when not full.
  - Push while full with no same-cycle pop: code is dropped and Key_Overflow is set (cleared only by reset).
  - Simultaneous push and pop when full: both succeed.
  - Simultaneous push and pop when empty: the pop is not allowed (empty) and the push lands.
  - Pointers wrap modulo KEY_DEPTH; count is log2(KEY_DEPTH)+1 bits.
- Unknown IO_Selection cannot occur (2-bit fully decoded).

Optional Feature:
Macro IO_CTRL_DEBOUNCE_EN.
- Defined: synchronised Enter must be stable for 2^16 consecutive cycles (16-bit counter, reset on any change) before its debounced level updates. Enter_Rise derives from the debounced level.
- Undefined: Enter_Rise comes directly from the synchroniser output. No counter is instantiated.

Decomposition:
- Package io_ctrl_pkg:
  - IO_SEL_OUT=0, IO_SEL_IN=1, IO_SEL_GETC=2, IO_SEL_DRAW=3
  - DRAW_PIXEL=0, DRAW_CHAR=1
  - 3-bit state typedef io_state_t
- Sub-module io_key_fifo (parameters KEY_DEPTH, width 8): ports push, pop, din, dout, empty, full, same Clock/Reset_n.

Test Plan:
- OUT with Op_A=0x0000_00A5 in IDLE -> IO_Stall=0 that cycle; Out_Display=0xA5 after the edge; state stays IDLE.
- IN with Switches=0x1234, Enter pulsed 10 cycles later -> IO_Stall high until Enter_Rise; DONE cycle shows IO_Read_Data=0x0000_1234 and IO_Stall=0; back to IDLE next cycle.
- GETC on empty FIFO, then Key_Valid with 0x41 -> push, pop next cycle, DONE with IO_Read_Data=0x41. With a key already queued -> exactly 1 stall cycle.
- Push 5 keys (0x30..0x34) with no GETC, KEY_DEPTH=4 -> Key_Overflow=1. Four GETCs return 0x30..0x33 in order.
- DWCH with Op_A=0x0102, Op_B=0x48, Draw_Ack delayed 7 cycles -> Draw_Req high 7 cycles; Draw_Mode=1; fields stable; stall released in DONE.
- Reset_n low during WAIT_IN -> next edge: state IDLE, IO_Stall=0, Draw_Req=0, FIFO empty, Key_Overflow=0.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: shared constants and state type for the IO control unit.
// Holds the IO_Selection and Draw_Select encodings used by decode.
package io_ctrl_pkg;

    // Encodings of IO_Selection coming from instruction decode
    localparam logic [1:0] IO_SEL_OUT  = 2'd0;
    localparam logic [1:0] IO_SEL_IN   = 2'd1;
    localparam logic [1:0] IO_SEL_GETC = 2'd2;
    localparam logic [1:0] IO_SEL_DRAW = 2'd3;

    // Encodings of Draw_Select (only meaningful for IO_SEL_DRAW)
    localparam logic [1:0] DRAW_PIXEL = 2'd0;
    localparam logic [1:0] DRAW_CHAR  = 2'd1;

    // Width of a keyboard scan code
    localparam int KEY_W = 8;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IN  = 3'd1,
        ST_WAIT_KEY = 3'd2,
        ST_DRAW     = 3'd3,
        ST_DONE     = 3'd4
    } io_state_t;

    // True when a draw mode selects character drawing rather than pixels
    function automatic logic is_char_mode(input logic [1:0] mode);
        return (mode == DRAW_CHAR) && (mode != DRAW_PIXEL);
    endfunction

endpackage

// File: rtl/io_key_fifo.sv
// io_key_fifo: small synchronous FIFO buffering keyboard codes for GETC.
// A push into a full FIFO is accepted only when a pop happens in the
// same cycle; a pop from an empty FIFO is ignored.
module io_key_fifo #(
    parameter int KEY_DEPTH = 4,
    parameter int WIDTH     = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(KEY_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(KEY_DEPTH);

    logic [WIDTH-1:0] mem [KEY_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_ctrl_unit.sv
// io_ctrl_unit: executes OUT, IN, GETC and DRAW (pixel/char) IO instructions,
// stalling the PC while an operation waits on the user, keyboard or drawer.
// Optional macro IO_CTRL_DEBOUNCE_EN adds a 2^16-cycle debounce on Enter.
import io_ctrl_pkg::*;

module io_ctrl_unit #(
    parameter int DATA_W    = 32,
    parameter int SW_W      = 16,
    parameter int KEY_DEPTH = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              IO_Enable,
    input  logic [1:0]        IO_Selection,
    input  logic [1:0]        Draw_Select,
    input  logic [DATA_W-1:0] Op_A,
    input  logic [DATA_W-1:0] Op_B,
    input  logic [SW_W-1:0]   Switches,
    input  logic              Enter_Btn,
    input  logic              Key_Valid,
    input  logic [KEY_W-1:0]  Key_Code,
    input  logic              Draw_Ack,
    output logic [DATA_W-1:0] IO_Read_Data,
    output logic              IO_Stall,
    output logic [DATA_W-1:0] Out_Display,
    output logic              Draw_Req,
    output logic [1:0]        Draw_Mode,
    output logic [DATA_W-1:0] Draw_Pos,
    output logic [DATA_W-1:0] Draw_Data,
    output logic              Key_Overflow
);

    io_state_t        state;
    io_state_t        state_next;

    logic             enter_sync1;
    logic             enter_sync2;
    logic             enter_level;
    logic             enter_prev;
    logic             enter_rise;

    logic             fifo_push;
    logic             fifo_pop;
    logic [KEY_W-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;

    logic             stall_c;

    // Two-flop synchroniser bringing the raw Enter button into the clock domain
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            enter_sync1 <= 1'b0;
            enter_sync2 <= 1'b0;
        end else begin
            enter_sync1 <= Enter_Btn;
            enter_sync2 <= enter_sync1;
        end
    end

`ifdef IO_CTRL_DEBOUNCE_EN
    logic [15:0] db_count;
    logic        db_level;
    logic        db_prev;

    // Debounced level follows the synchronised input only after it has been stable long enough
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            db_count <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            db_prev <= enter_sync2;
            if (enter_sync2 != db_prev) begin
                db_count <= '0;
            end else if (enter_sync2 != db_level) begin
                if (db_count == 16'hFFFF) begin
                    db_level <= enter_sync2;
                    db_count <= '0;
                end else begin
                    db_count <= db_count + 16'd1;
                end
            end else begin
                db_count <= '0;
            end
        end
    end

    assign enter_level = db_level;
`else
    assign enter_level = enter_sync2;
`endif

    // Registered rising-edge detect giving a single-cycle Enter pulse
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            enter_prev <= 1'b0;
            enter_rise <= 1'b0;
        end else begin
            enter_prev <= enter_level;
            enter_rise <= enter_level & ~enter_prev;
        end
    end

    // Keyboard codes are always offered to the FIFO; GETC pops when data is ready
    assign fifo_push = Key_Valid;
    assign fifo_pop  = (state == ST_WAIT_KEY) & ~fifo_empty;

    io_key_fifo #(
        .KEY_DEPTH (KEY_DEPTH),
        .WIDTH     (KEY_W)
    ) u_key_fifo (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (Key_Code),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stall decode; DONE never stalls so the instruction can retire
    always_comb begin
        state_next = state;
        stall_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (IO_Enable) begin
                    stall_c = (IO_Selection != IO_SEL_OUT);
                    case (IO_Selection)
                        IO_SEL_IN:   state_next = ST_WAIT_IN;
                        IO_SEL_GETC: state_next = ST_WAIT_KEY;
                        IO_SEL_DRAW: state_next = ST_DRAW;
                        default:     state_next = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_IN: begin
                stall_c = 1'b1;
                if (enter_rise) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT_KEY: begin
                stall_c = 1'b1;
                if (!fifo_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DRAW: begin
                stall_c = 1'b1;
                if (Draw_Ack) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign IO_Stall = stall_c;

    // Output latches: display value, read-back data and draw request fields
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Out_Display  <= '0;
            IO_Read_Data <= '0;
            Draw_Req     <= 1'b0;
            Draw_Mode    <= '0;
            Draw_Pos     <= '0;
            Draw_Data    <= '0;
        end else begin
            if (state == ST_IDLE && IO_Enable) begin
                if (IO_Selection == IO_SEL_OUT) begin
                    Out_Display <= Op_A;
                end
                if (IO_Selection == IO_SEL_DRAW) begin
                    Draw_Mode <= Draw_Select;
                    Draw_Pos  <= Op_A;
                    Draw_Data <= Op_B;
                    Draw_Req  <= 1'b1;
                end
            end
            if (state == ST_WAIT_IN && enter_rise) begin
                IO_Read_Data <= {{(DATA_W - SW_W){1'b0}}, Switches};
            end
            if (state == ST_WAIT_KEY && !fifo_empty) begin
                IO_Read_Data <= {{(DATA_W - KEY_W){1'b0}}, fifo_dout};
            end
            if (state == ST_DRAW && Draw_Ack) begin
                Draw_Req <= 1'b0;
            end
        end
    end

    // Sticky flag for a key code lost because the FIFO had no room
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Key_Overflow <= 1'b0;
        end else if (Key_Valid && fifo_full && !fifo_pop) begin
            Key_Overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_ctrl_unit.sv
// tb_io_ctrl_unit: directed plus randomized bench for io_ctrl_unit, checked
// against a queue-based model of the keyboard buffer and expected outputs.
module tb_io_ctrl_unit;

    localparam int DATA_W    = 32;
    localparam int SW_W      = 16;
    localparam int KEY_DEPTH = 4;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic              IO_Enable;
    logic [1:0]        IO_Selection;
    logic [1:0]        Draw_Select;
    logic [DATA_W-1:0] Op_A;
    logic [DATA_W-1:0] Op_B;
    logic [SW_W-1:0]   Switches;
    logic              Enter_Btn;
    logic              Key_Valid;
    logic [7:0]        Key_Code;
    logic              Draw_Ack;
    logic [DATA_W-1:0] IO_Read_Data;
    logic              IO_Stall;
    logic [DATA_W-1:0] Out_Display;
    logic              Draw_Req;
    logic [1:0]        Draw_Mode;
    logic [DATA_W-1:0] Draw_Pos;
    logic [DATA_W-1:0] Draw_Data;
    logic              Key_Overflow;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] key_q[$];
    logic       exp_ovf;

    io_ctrl_unit #(
        .DATA_W    (DATA_W),
        .SW_W      (SW_W),
        .KEY_DEPTH (KEY_DEPTH)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .IO_Enable    (IO_Enable),
        .IO_Selection (IO_Selection),
        .Draw_Select  (Draw_Select),
        .Op_A         (Op_A),
        .Op_B         (Op_B),
        .Switches     (Switches),
        .Enter_Btn    (Enter_Btn),
        .Key_Valid    (Key_Valid),
        .Key_Code     (Key_Code),
        .Draw_Ack     (Draw_Ack),
        .IO_Read_Data (IO_Read_Data),
        .IO_Stall     (IO_Stall),
        .Out_Display  (Out_Display),
        .Draw_Req     (Draw_Req),
        .Draw_Mode    (Draw_Mode),
        .Draw_Pos     (Draw_Pos),
        .Draw_Data    (Draw_Data),
        .Key_Overflow (Key_Overflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reset the DUT and the model together
    task automatic do_reset(input int cycles);
        Reset_n = 1'b0;
        IO_Enable = 1'b0;
        Key_Valid = 1'b0;
        Draw_Ack = 1'b0;
        Enter_Btn = 1'b0;
        repeat (cycles) @(negedge Clock);
        key_q.delete();
        exp_ovf = 1'b0;
    endtask

    // A key arriving while the controller is idle
    task automatic push_key(input logic [7:0] code);
        Key_Valid = 1'b1;
        Key_Code  = code;
        @(negedge Clock);
        Key_Valid = 1'b0;
        if (key_q.size() < KEY_DEPTH) key_q.push_back(code);
        else exp_ovf = 1'b1;
    endtask

    task automatic do_out(input logic [31:0] val);
        IO_Enable = 1'b1;
        IO_Selection = 2'd0;
        Op_A = val;
        #1 check("out_no_stall", 32'(IO_Stall), 32'd0);
        @(negedge Clock);
        IO_Enable = 1'b0;
        Op_A = $urandom;
        #1 check("out_display", Out_Display, val);
    endtask

    task automatic do_in(input logic [15:0] sw, input int delay);
        logic held;
        logic done;
        Switches = sw;
        IO_Enable = 1'b1;
        IO_Selection = 2'd1;
        #1 check("in_issue_stall", 32'(IO_Stall), 32'd1);
        @(negedge Clock);
        IO_Enable = 1'b0;
        held = 1'b1;
        repeat (delay) begin
            if (!IO_Stall) held = 1'b0;
            @(negedge Clock);
        end
        check("in_wait_stall", 32'(held), 32'd1);
        Enter_Btn = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge Clock);
            if (c == 2) Enter_Btn = 1'b0;
            if (!IO_Stall) done = 1'b1;
        end
        Enter_Btn = 1'b0;
        check("in_done", 32'(done), 32'd1);
        check("in_read", IO_Read_Data, {16'h0, sw});
        @(negedge Clock);
        Switches = 16'($urandom);
        #1 check("in_hold", IO_Read_Data, {16'h0, sw});
        repeat (4) @(negedge Clock);
    endtask

    task automatic do_getc(input int inject_at, input logic [7:0] code);
        int   stalls;
        int   exp_stalls;
        logic done;
        exp_stalls = (key_q.size() > 0) ? 1 : inject_at + 2;
        IO_Enable = 1'b1;
        IO_Selection = 2'd2;
        #1 check("getc_issue_stall", 32'(IO_Stall), 32'd1);
        @(negedge Clock);
        IO_Enable = 1'b0;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (IO_Stall) begin
                stalls++;
                if (c == inject_at) begin
                    Key_Valid = 1'b1;
                    Key_Code  = code;
                    key_q.push_back(code);
                end
                @(negedge Clock);
                Key_Valid = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        check("getc_done", 32'(done), 32'd1);
        check("getc_stalls", 32'(stalls), 32'(exp_stalls));
        if (key_q.size() > 0) check("getc_data", IO_Read_Data, {24'h0, key_q.pop_front()});
        else check("getc_model_nonempty", 32'(key_q.size()), 32'd1);
        check("getc_ovf", 32'(Key_Overflow), 32'(exp_ovf));
        @(negedge Clock);
    endtask

    task automatic do_draw(input logic [1:0] mode, input logic [31:0] pos,
                           input logic [31:0] data, input int delay);
        int   high;
        logic stable;
        IO_Enable = 1'b1;
        IO_Selection = 2'd3;
        Draw_Select = mode;
        Op_A = pos;
        Op_B = data;
        #1 check("draw_issue_stall", 32'(IO_Stall), 32'd1);
        @(negedge Clock);
        IO_Enable = 1'b0;
        Op_A = $urandom;
        Op_B = $urandom;
        Draw_Select = 2'($urandom);
        high = 0;
        stable = 1'b1;
        for (int c = 0; c < delay; c++) begin
            if (Draw_Req) high++;
            if (Draw_Mode !== mode || Draw_Pos !== pos || Draw_Data !== data || !IO_Stall)
                stable = 1'b0;
            if (c == delay - 1) Draw_Ack = 1'b1;
            @(negedge Clock);
        end
        Draw_Ack = 1'b0;
        check("draw_req_cycles", 32'(high), 32'(delay));
        check("draw_fields_stable", 32'(stable), 32'd1);
        check("draw_req_dropped", 32'(Draw_Req), 32'd0);
        check("draw_done_no_stall", 32'(IO_Stall), 32'd0);
        check("draw_pos_held", Draw_Pos, pos);
        @(negedge Clock);
    endtask

    initial begin
        int op;
        IO_Selection = 2'd0;
        Draw_Select  = 2'd0;
        Op_A = '0;
        Op_B = '0;
        Switches = '0;
        Key_Code = '0;
        do_reset(3);

        // Reset state
        check("rst_stall", 32'(IO_Stall), 32'd0);
        check("rst_out_display", Out_Display, 32'd0);
        check("rst_read_data", IO_Read_Data, 32'd0);
        check("rst_draw_req", 32'(Draw_Req), 32'd0);
        check("rst_draw_pos", Draw_Pos, 32'd0);
        check("rst_overflow", 32'(Key_Overflow), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clock);

        // OUT
        do_out(32'h0000_00A5);
        repeat (3) do_out($urandom);

        // Enter pressed while idle must not complete a later IN
        Enter_Btn = 1'b1;
        repeat (3) @(negedge Clock);
        Enter_Btn = 1'b0;
        repeat (6) @(negedge Clock);
        do_in(16'h1234, 10);
        repeat (2) do_in(16'($urandom), $urandom_range(2, 6));

        // GETC on empty FIFO, then with a key already queued
        do_getc(2, 8'h41);
        push_key(8'($urandom));
        do_getc(-1, 8'h00);

        // Full FIFO with simultaneous push and pop
        repeat (KEY_DEPTH) push_key(8'($urandom));
        check("full_no_ovf", 32'(Key_Overflow), 32'd0);
        do_getc(0, 8'($urandom));
        repeat (KEY_DEPTH) do_getc(-1, 8'h00);

        // Overflow: five keys into a four-entry buffer
        for (int k = 0; k < 5; k++) push_key(8'(8'h30 + k));
        check("overflow_set", 32'(Key_Overflow), 32'd1);
        repeat (KEY_DEPTH) do_getc(-1, 8'h00);

        // Draw character with delayed ack, then random draws
        do_draw(2'd1, 32'h0000_0102, 32'h0000_0048, 7);
        repeat (3) do_draw(2'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(1, 5));

        // Random mix of operations
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2)) push_key(8'($urandom));
            check("rand_ovf", 32'(Key_Overflow), 32'(exp_ovf));
            op = $urandom_range(0, 3);
            case (op)
                0: do_out($urandom);
                1: do_in(16'($urandom), $urandom_range(1, 4));
                2: do_getc((key_q.size() > 0) ? -1 : $urandom_range(0, 3), 8'($urandom));
                default: do_draw(2'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(1, 5));
            endcase
        end

        // Reset during WAIT_IN clears everything
        for (int k = 0; k < 5; k++) push_key(8'($urandom));
        IO_Enable = 1'b1;
        IO_Selection = 2'd1;
        @(negedge Clock);
        IO_Enable = 1'b0;
        repeat (3) @(negedge Clock);
        do_reset(1);
        check("midrst_stall", 32'(IO_Stall), 32'd0);
        check("midrst_draw_req", 32'(Draw_Req), 32'd0);
        check("midrst_overflow", 32'(Key_Overflow), 32'd0);
        check("midrst_read_data", IO_Read_Data, 32'd0);
        Reset_n = 1'b1;
        @(negedge Clock);
        do_getc(2, 8'h5A);

        // Reset during DRAW drops the request at the next edge
        IO_Enable = 1'b1;
        IO_Selection = 2'd3;
        Op_A = $urandom;
        @(negedge Clock);
        IO_Enable = 1'b0;
        check("drawrst_req_before", 32'(Draw_Req), 32'd1);
        @(negedge Clock);
        do_reset(1);
        check("drawrst_req", 32'(Draw_Req), 32'd0);
        check("drawrst_stall", 32'(IO_Stall), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clock);

        $display("[TB] run complete");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
